// File: rtl/bitlogic_pkg.sv
// Shared types and limits for the bitlogic_acc slice: the per-bit op encoding,
// the accumulator sequencing state, and the legal operand width range.
package bitlogic_pkg;

   localparam int unsigned WIDTH_MIN = 1;
   localparam int unsigned WIDTH_MAX = 64;

   typedef enum logic [2:0] {
      OP_AND  = 3'd0,
      OP_OR   = 3'd1,
      OP_XOR  = 3'd2,
      OP_NAND = 3'd3,
      OP_NOR  = 3'd4,
      OP_XNOR = 3'd5,
      OP_ANDN = 3'd6,
      OP_PASS = 3'd7
   } op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_ACC  = 1'b1
   } acc_state_t;

endpackage

// File: rtl/bitlogic_op.sv
// Combinational bitwise operator: r = op(a, b), applied independently per bit.
module bitlogic_op
   import bitlogic_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  op_t              op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] r
);

   always_comb begin
      r = a;
      case (op)
         OP_AND:  r = a & b;
         OP_OR:   r = a | b;
         OP_XOR:  r = a ^ b;
         OP_NAND: r = ~(a & b);
         OP_NOR:  r = ~(a | b);
         OP_XNOR: r = ~(a ^ b);
         OP_ANDN: r = a & ~b;
         OP_PASS: r = a;
         default: r = a;
      endcase
   end

endmodule

// File: rtl/bitlogic_acc.sv
// Bitwise-op unit with optional multi-beat accumulation and a one-deep output register.
// Define BITLOGIC_ACC_POPCOUNT_EN to add the registered out_pop ones-count output.
module bitlogic_acc
   import bitlogic_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc,
   input  logic             last,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             out_zero
`ifdef BITLOGIC_ACC_POPCOUNT_EN
   ,
   output logic [$clog2(WIDTH+1)-1:0] out_pop
`else
`endif
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("bitlogic_acc: WIDTH out of range");
   end

   acc_state_t       state_q, state_d;
   logic             acc_active;
   logic             accept;
   logic             load_out;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] opnd_b;
   logic [WIDTH-1:0] op_r;
   logic [WIDTH-1:0] acc_upd;
   logic [WIDTH-1:0] out_d;
   logic [WIDTH-1:0] out_q;
   logic             out_valid_q;
   logic             out_zero_q;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_zero  = out_zero_q;

   // Accumulate beats feed the running value back as operand B; y is unused then.
   assign opnd_b = acc ? acc_q : y;

   bitlogic_op #(.WIDTH(WIDTH)) u_op (
      .op (op_t'(op)),
      .a  (x),
      .b  (opnd_b),
      .r  (op_r)
   );

   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (accept && acc) state_d = last ? ST_IDLE : ST_ACC;
   end

   always_comb begin
      acc_active = (state_q == ST_ACC);
   end

   always_comb begin
      acc_upd  = acc_active ? op_r : x;
      out_d    = acc ? acc_upd : op_r;
      load_out = accept && (!acc || last);
      acc_d    = acc_q;
      if (accept && acc) acc_d = last ? '0 : acc_upd;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         out_q       <= '0;
         out_zero_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         acc_q <= acc_d;
         if (load_out) begin
            out_q       <= out_d;
            out_zero_q  <= (out_d == '0);
            out_valid_q <= 1'b1;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

`ifdef BITLOGIC_ACC_POPCOUNT_EN
   localparam int unsigned PW = $clog2(WIDTH + 1);

   logic [PW-1:0] pop_d, pop_q;

   always_comb begin
      pop_d = '0;
      for (int unsigned i = 0; i < WIDTH; i++) pop_d = pop_d + PW'(out_d[i]);
   end

   always_ff @(posedge clk) begin
      if (rst)           pop_q <= '0;
      else if (load_out) pop_q <= pop_d;
   end

   assign out_pop = pop_q;
`else
   // No popcount output in this build.
`endif

endmodule

// File: doc/bitlogic_acc.md
BITLOGIC_ACC -- requirements
Module: bitlogic_acc

Interface
REQ-001 Parameter WIDTH, default 8, operand and result width in bits, legal range 1..64.
REQ-002 Port clk  input  1  single clock; all state updates on the rising edge.
REQ-003 Port rst  input  1  reset, synchronous, active-high.
REQ-004 Port in_valid  input  1  an input beat is offered.
REQ-005 Port in_ready  output  1  the block accepts the offered beat this cycle.
REQ-006 Port op  input  3  operation select, sampled with the beat.
REQ-007 Port acc  input  1  the beat belongs to an accumulation sequence.
REQ-008 Port last  input  1  final beat of an accumulation sequence; ignored when acc=0.
REQ-009 Port x  input  WIDTH  operand A.
REQ-010 Port y  input  WIDTH  operand B; ignored when acc=1.
REQ-011 Port out_valid  output  1  the result is valid.
REQ-012 Port out_ready  input  1  the downstream consumer takes the result.
REQ-013 Port out  output  WIDTH  registered result.
REQ-014 Port out_zero  output  1  registered flag, high when out == 0.

Function
REQ-015 op encoding SHALL be: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (x & ~y), 7 PASS (x); the operation is bitwise per bit, with no carries.
REQ-016 A beat is accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready, combinationally, with no path from in_valid.
REQ-017 Non-accumulate beat (acc=0): out = op(x,y) and out_valid=1 on the cycle after acceptance; latency 1.
REQ-018 Accumulate, first beat (acc_active=0): the accumulator loads x and acc_active is set; no output is produced unless last=1.
REQ-019 Accumulate, subsequent beat: accumulator = op(x, accumulator), using each beat's own op.
REQ-020 Accumulate beat with last=1: out = the updated accumulator value, out_valid=1 next cycle; accumulator cleared to 0 and acc_active cleared in the same edge.
REQ-021 A single beat with acc=1 and last=1 and acc_active=0 SHALL output x unchanged, regardless of op.
REQ-022 A non-accumulate beat arriving while acc_active=1 is processed per REQ-017 and leaves the accumulator and acc_active untouched.
REQ-023 Accumulate beats without last are always accepted while in_ready=1, even though they produce no output.
REQ-024 out, out_zero and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 out_valid clears on out_ready when no new result is loaded; it stays high on back-to-back accept plus drain (full throughput, one beat per cycle).

Reset
REQ-026 On rst=1 at an edge: out_valid=0, out=0, out_zero=1, accumulator=0, acc_active=0; in_ready=1 in the following cycle.
REQ-027 A reset asserted mid-accumulation SHALL discard the partial sequence; the next acc beat is treated as a first beat.
REQ-028 Reset SHALL override a simultaneous accepted beat; that beat is lost.

Configuration
REQ-029 Macro BITLOGIC_ACC_POPCOUNT_EN, when defined, adds output out_pop, width clog2(WIDTH+1), registered with out and equal to the number of ones in out, reset to 0.
REQ-030 Without BITLOGIC_ACC_POPCOUNT_EN, out_pop SHALL be absent and no popcount logic SHALL be synthesised.

Structure
REQ-031 Package bitlogic_pkg SHALL hold the op enum (OP_AND..OP_PASS) and the WIDTH limits constant.
REQ-032 The combinational per-op datapath SHALL be sub-module bitlogic_op (inputs op, a, b; output r, all WIDTH-parameterised); bitlogic_acc owns the handshake, accumulator and output registers.

Verification
REQ-033 WIDTH=8, op=OR, acc=0, x=0xA0, y=0x05, out_ready=1 -> out=0xA5 and out_valid=1 one cycle later; out_zero=0.
REQ-034 op=AND sequence, acc=1: x=0xFF, 0xF0, 0x3C with last on the third beat -> a single output of 0x30, and no out_valid on beats 1-2.
REQ-035 out_ready=0 for 3 cycles after a result -> out is held, in_ready=0, and the next beat is accepted only when out_ready=1.
REQ-036 Mid-sequence XOR accumulation (two beats: 0x0F, 0xFF), then rst pulse, then acc beat x=0x11 with last=1 -> out=0x11.
REQ-037 Interleaved: acc beat 0x0F (op OR), then acc=0 op=NOR x=0,y=0, then acc last beat 0xF0 (op OR) -> outputs 0xFF then 0xFF, in that order.
REQ-038 With BITLOGIC_ACC_POPCOUNT_EN and WIDTH=8: a result of 0xA5 -> out_pop=4; XOR x=y=0x5A -> out=0x00, out_zero=1, out_pop=0.
